// File: rtl/logic_op_identifier.sv
// Probe for a 2-input selectable logic unit: steps {A,B} through 00..11, samples Y,
// and decodes the captured truth table back into the sel_grp/sel_op code.
module logic_op_identifier #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       Y,
   output logic       A,
   output logic       B,
   output logic       busy,
   output logic       done,
   output logic       valid,
   output logic       sel_grp,
   output logic       sel_op,
   output logic [3:0] resp
);

   typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state_reg;
   logic [1:0] idx_reg;
   logic [3:0] cnt_reg;
   logic [3:0] shadow_reg;

   logic [1:0] idx_next;
   logic [3:0] table_next;
   logic       valid_next;
   logic       grp_next;
   logic       op_next;

   // The final vector's Y is folded in directly so the decode lands on DONE entry.
   always_comb begin
      idx_next   = idx_reg + 2'd1;
      table_next = {Y, shadow_reg[2:0]};
      valid_next = 1'b0;
      grp_next   = 1'b0;
      op_next    = 1'b0;
      case (table_next)
         4'b1000: begin valid_next = 1'b1; grp_next = 1'b1; op_next = 1'b0; end
         4'b0111: begin valid_next = 1'b1; grp_next = 1'b1; op_next = 1'b1; end
         4'b1110: begin valid_next = 1'b1; grp_next = 1'b0; op_next = 1'b0; end
         4'b0001: begin valid_next = 1'b1; grp_next = 1'b0; op_next = 1'b1; end
         default: begin valid_next = 1'b0; grp_next = 1'b0; op_next = 1'b0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         idx_reg    <= 2'd0;
         cnt_reg    <= 4'd0;
         shadow_reg <= 4'd0;
         A          <= 1'b0;
         B          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         valid      <= 1'b0;
         sel_grp    <= 1'b0;
         sel_op     <= 1'b0;
         resp       <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  idx_reg    <= 2'd0;
                  cnt_reg    <= 4'd0;
                  shadow_reg <= 4'd0;
                  A          <= 1'b0;
                  B          <= 1'b0;
                  busy       <= 1'b1;
                  state_reg  <= APPLY;
               end
            end
            APPLY: begin
               if (cnt_reg == SETTLE_LAST) begin
                  cnt_reg   <= 4'd0;
                  state_reg <= CAPTURE;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            CAPTURE: begin
               shadow_reg[idx_reg] <= Y;
               if (idx_reg == 2'd3) begin
                  A         <= 1'b0;
                  B         <= 1'b0;
                  resp      <= table_next;
                  valid     <= valid_next;
                  sel_grp   <= grp_next;
                  sel_op    <= op_next;
                  done      <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  idx_reg   <= idx_next;
                  A         <= idx_next[1];
                  B         <= idx_next[0];
                  state_reg <= APPLY;
               end
            end
            DONE: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_op_identifier.sv
// Bench for logic_op_identifier: golden logic-unit models drive Y, a table-level
// reference decodes the expected operation, and every comparison is an immediate assertion.
module tb_logic_op_identifier;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // SETTLE=1 instance
   logic       start1, a1, b1, busy1, done1, valid1, grp1, op1;
   logic [3:0] resp1, tbl1;
   logic       y1;
   assign y1 = tbl1[{a1, b1}];

   // SETTLE=3 instance
   logic       start3, a3, b3, busy3, done3, valid3, grp3, op3;
   logic [3:0] resp3, tbl3;
   logic       y3;
   assign y3 = tbl3[{a3, b3}];

   logic_op_identifier #(.SETTLE(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .Y(y1), .A(a1), .B(b1), .busy(busy1),
      .done(done1), .valid(valid1), .sel_grp(grp1), .sel_op(op1), .resp(resp1)
   );

   logic_op_identifier #(.SETTLE(3)) u3 (
      .clk(clk), .rst(rst), .start(start3), .Y(y3), .A(a3), .B(b3), .busy(busy3),
      .done(done3), .valid(valid3), .sel_grp(grp3), .sel_op(op3), .resp(resp3)
   );

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [3:0] T_AND  = 4'b1000;
   localparam logic [3:0] T_NAND = 4'b0111;
   localparam logic [3:0] T_OR   = 4'b1110;
   localparam logic [3:0] T_NOR  = 4'b0001;
   localparam logic [3:0] T_XOR  = 4'b0110;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected {valid, sel_grp, sel_op}: build each named operation's truth table
   // from its boolean rule and see which one the response matches.
   function automatic logic [2:0] ref_decode(input logic [3:0] t);
      logic [3:0] t_and, t_nand, t_or, t_nor;
      for (int i = 0; i < 4; i++) begin
         int a, b;
         a = (i >> 1) & 1;
         b = i & 1;
         t_and[i]  = ((a & b) != 0);
         t_nand[i] = ((a & b) == 0);
         t_or[i]   = ((a | b) != 0);
         t_nor[i]  = ((a | b) == 0);
      end
      if (t == t_and)  return 3'b110;
      if (t == t_nand) return 3'b111;
      if (t == t_or)   return 3'b100;
      if (t == t_nor)  return 3'b101;
      return 3'b000;
   endfunction

   // Starts a SETTLE=1 run from a negedge in IDLE and checks it cycle by cycle;
   // k counts negedges after the edge that samples start. Optionally pokes start
   // during the first CAPTURE (k=2) and the DONE cycle (k=9).
   task automatic run1(input logic [3:0] t, input bit poke, input string tag);
      logic [3:0] prev_resp;
      logic [2:0] prev_dec, exp_dec;
      tbl1      = t;
      prev_resp = resp1;
      prev_dec  = {valid1, grp1, op1};
      exp_dec   = ref_decode(t);
      start1    = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         chk($sformatf("%s_done_k%0d", tag, k), {7'd0, done1}, {7'd0, (k == 9)});
         chk($sformatf("%s_busy_k%0d", tag, k), {7'd0, busy1}, {7'd0, (k <= 9)});
         if (k < 9) begin
            chk($sformatf("%s_resp_hold_k%0d", tag, k), {4'd0, resp1}, {4'd0, prev_resp});
            chk($sformatf("%s_dec_hold_k%0d", tag, k), {5'd0, valid1, grp1, op1}, {5'd0, prev_dec});
         end else begin
            chk($sformatf("%s_resp_k%0d", tag, k), {4'd0, resp1}, {4'd0, t});
            chk($sformatf("%s_dec_k%0d", tag, k), {5'd0, valid1, grp1, op1}, {5'd0, exp_dec});
         end
         start1 = poke && (k == 2 || k == 9);
         @(negedge clk);
      end
      start1 = 1'b0;
      $display("run %s table=%b resp=%b valid=%0d grp=%0d op=%0d", tag, t, resp1, valid1, grp1, op1);
   endtask

   initial begin
      logic [3:0] rt;
      rst = 1'b1; start1 = 1'b0; start3 = 1'b0; tbl1 = 4'd0; tbl3 = 4'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("reset_u1", {a1, b1, busy1, done1, valid1, grp1, op1, 1'b0}, 8'd0);
      chk("reset_resp_u1", {4'd0, resp1}, 8'd0);
      chk("reset_u3", {a3, b3, busy3, done3, valid3, grp3, op3, 1'b0}, 8'd0);
      $display("reset checked");

      // Known operations, then an OR->NAND pair exercising output hold.
      run1(T_AND,  1'b0, "and");
      run1(T_NOR,  1'b0, "nor");
      run1(T_OR,   1'b0, "or");
      run1(T_NAND, 1'b0, "nand_after_or");
      run1(T_XOR,  1'b0, "xor");
      run1(T_OR,   1'b1, "or_busy_poke");

      // Reset in the middle of a NAND run that follows a completed AND run.
      run1(T_AND, 1'b0, "and_pre_rst");
      tbl1   = T_NAND;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int k = 1; k < 5; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_flags", {a1, b1, busy1, done1, valid1, grp1, op1, 1'b0}, 8'd0);
      chk("midrst_resp", {4'd0, resp1}, 8'd0);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk($sformatf("midrst_nodone_%0d", k), {6'd0, busy1, done1}, 8'd0);
      end
      $display("mid-run reset checked resp=%b", resp1);
      run1(T_NAND, 1'b0, "nand_after_rst");

      // Random truth tables against the reference decode.
      for (int r = 0; r < 8; r++) begin
         rt = 4'($urandom_range(0, 15));
         run1(rt, 1'b0, $sformatf("rand%0d", r));
      end

      // Drive sequence with SETTLE=3: each vector held 4 cycles, then 0/0.
      tbl3   = 4'($urandom_range(0, 15));
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         int v;
         v = (k <= 16) ? (k - 1) / 4 : 0;
         chk($sformatf("s3_ab_k%0d", k), {6'd0, a3, b3}, 8'(v));
         chk($sformatf("s3_done_k%0d", k), {7'd0, done3}, {7'd0, (k == 17)});
         chk($sformatf("s3_busy_k%0d", k), {7'd0, busy3}, {7'd0, (k <= 17)});
         if (k == 17) begin
            chk("s3_resp", {4'd0, resp3}, {4'd0, tbl3});
            chk("s3_dec", {5'd0, valid3, grp3, op3}, {5'd0, ref_decode(tbl3)});
         end
         @(negedge clk);
      end
      $display("settle3 run table=%b resp=%b", tbl3, resp3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/logic_op_identifier.md
# logic_op_identifier

Sequential probe for the 2-input selectable logic unit: given the unit's output `Y`, it works out which operation is selected. It drives each of the four `{A,B}` input vectors in turn and samples `Y` after a settle delay. It then decodes the 4-bit truth table back into the `sel_grp`/`sel_op` code that produces it. It sits on the other side of the logic unit from the select logic and is used for self-test and bring-up of that unit.

## Interface
Parameters:
- `SETTLE`, default 1: cycles `A`/`B` are held before `Y` is sampled. Legal range is 1..15; the counter is 4 bits.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a probe run; sampled only in IDLE.
- `Y`  in  1: output of the logic unit under probe.
- `A`  out  1: operand A driven to the unit.
- `B`  out  1: operand B driven to the unit.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse when the results update.
- `valid`  out  1: last run matched a known operation.
- `sel_grp`  out  1: decoded group; 1 = AND/NAND, 0 = OR/NOR.
- `sel_op`  out  1: decoded op; 0 = AND or OR, 1 = NAND or NOR.
- `resp`  out  4: captured truth table; `resp[i]` = `Y` for `{A,B}` = i.

## Operation
- **Reset values:** state = IDLE; `A`=`B`=0; `busy`=`done`=`valid`=0; `sel_grp`=`sel_op`=0; `resp`=4'b0000. Internal index, counter and shadow table are all cleared.
- **States:**
  - IDLE: if `start`=1, clear the index and shadow table and go to APPLY.
  - APPLY: drive `A`=idx[1] and `B`=idx[0]. Hold for `SETTLE` cycles, then go to CAPTURE.
  - CAPTURE: keep `A`/`B` driven. On the edge that ends this cycle, shadow[idx] <= `Y`. If idx=3, go to DONE; otherwise idx+1 and go to APPLY.
  - DONE: `done`=1 for exactly one cycle. Load outputs from the shadow table, then go to IDLE.
- **Vector order:** idx 0,1,2,3, giving `{A,B}` = 00, 01, 10, 11.
- **`A`/`B` outside APPLY/CAPTURE:** 0.
- **Decode,** registered at entry to DONE from the shadow table. Every other pattern sets `valid`=0, `sel_grp`=0, `sel_op`=0.
  - 4'b1000 (AND): `valid`=1, `sel_grp`=1, `sel_op`=0.
  - 4'b0111 (NAND): `valid`=1, `sel_grp`=1, `sel_op`=1.
  - 4'b1110 (OR): `valid`=1, `sel_grp`=0, `sel_op`=0.
  - 4'b0001 (NOR): `valid`=1, `sel_grp`=0, `sel_op`=1.
- **Output hold:** `resp`, `valid`, `sel_grp` and `sel_op` change only at the DONE update. They hold from there until the next DONE or `rst`, and do not change during a run.
- **`start` outside IDLE:** ignored, including in the DONE cycle; it is not queued.
- **`rst` mid-run:** immediate return to IDLE on the next edge with all reset values. No partial result is published.

## Timing
- `start` is sampled high at edge E0.
- The first APPLY cycle follows E0; `busy`=1 from E0+ onward.
- Each vector takes `SETTLE`+1 cycles (APPLY plus CAPTURE).
- `done`=1, and the new results are visible, in the cycle after edge E0+4·(`SETTLE`+1).
- `busy` falls in the cycle after that.
- Overall: `done` is 4·(`SETTLE`+1)+1 cycles after `start`, which is 9 cycles for `SETTLE`=1.
- `Y` is sampled at least `SETTLE`+1 edges after `A`/`B` change, so a combinational unit settles in time.
- Earliest restart: the first IDLE cycle after DONE, so runs repeat every 4·(`SETTLE`+1)+2 cycles.

## Test plan
- **Known operations:** with a golden logic-unit model, `SETTLE`=1, run all four codes. Required:
  - AND: `resp`=1000, `sel_grp`=1, `sel_op`=0, `valid`=1.
  - NAND: `resp`=0111, `sel_grp`=1, `sel_op`=1, `valid`=1.
  - OR: `resp`=1110, `sel_grp`=0, `sel_op`=0, `valid`=1.
  - NOR: `resp`=0001, `sel_grp`=0, `sel_op`=1, `valid`=1.
  - Every run: `done` is high exactly 9 cycles after `start`, for a single cycle.
- **Unknown operation:** the unit is replaced by XOR → `resp`=0110, `valid`=0, `sel_grp`=`sel_op`=0.
- **Drive sequence:** monitor `A`/`B` during a run with `SETTLE`=3 → 00, 01, 10, 11, each held 4 cycles, then 0/0 in DONE and IDLE.
- **Busy handling:** pulse `start` during CAPTURE and again in the DONE cycle → neither is accepted. Exactly one `done` occurs, and `busy` drops 1 cycle after `done`.
- **Reset mid-run:** assert `rst` at cycle 5 of a NAND run that follows a completed AND run.
  - Required next cycle: all outputs at reset values (`resp`=0000, `valid`=0, `sel_grp`=`sel_op`=0), `busy`=0, and no `done`.
  - A new NAND run must then complete with `resp`=0111.
- **Output hold:** complete an OR run, then start a NAND run → `resp`=1110 and `sel_op`=0 hold throughout the run. They switch to `resp`=0111 and `sel_op`=1 exactly in the `done` cycle.
